dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port. It accepts one word-sized load or store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It then performs the access on an internal word array and returns a single-cycle response carrying read data and an error flag. It sits between the pipeline's stage-4 memory access (address, store data, read/write strobes) and the backing storage. It replaces the zero-latency data memory when memory latency must be modelled.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the stage-4 memory access and dmem_responder.
interface dmem_responder_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word load/store, programmable wait
// states, single-cycle response with read data and error flag.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic            CLK,
  input logic            Reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              acc_en;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic [DATA_W-1:0] acc_rdata;
  logic              mem_we;

  // With zero wait states the access uses the live request on the accept edge.
  always_comb begin
    acc_en    = 1'b0;
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_en    = bus.req_valid && (WAIT_STATES == 0);
    end else if (state_q == ST_WAIT) begin
      acc_en    = (cnt_q == CNT_W'(1));
    end
  end

  always_comb begin
    acc_idx   = acc_addr[IDX_W+1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                (32'(acc_addr[ADDR_W-1:2]) >= DEPTH_WORDS);
    acc_rdata = (!acc_write && !acc_err) ? mem_q[acc_idx] : '0;
    mem_we    = acc_en && acc_write && !acc_err;
  end

  // Next-state and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (acc_en) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = acc_rdata;
      resp_err_d   = acc_err;
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  // Storage survives reset; a write pending while reset is high is dropped.
  always_ff @(negedge CLK) begin
    if (mem_we && !Reset) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign bus.req_ready  = ready_q && !Reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with 0.
module tb_dmem_responder;
  logic CLK;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  dmem_responder_if if2 ();
  dmem_responder_if if0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .Reset(Reset), .bus(if2.slave)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .Reset(Reset), .bus(if0.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_write = wr; if0.req_addr = addr; if0.req_wdata = wdata;
    end else begin
      if2.req_valid = v; if2.req_write = wr; if2.req_addr = addr; if2.req_wdata = wdata;
    end
  endtask

  function automatic logic rv(input int sel);
    return (sel == 0) ? if0.resp_valid : if2.resp_valid;
  endfunction

  // Issue one request from mid-cycle; report latency in edges after the accept edge.
  task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    int  k;
    bit  seen;
    k = 0; seen = 0; lat = -1; rdata = '0; err = 1'b0;
    drive(sel, 1'b1, wr, addr, wdata);
    @(negedge CLK);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK);
      if (i == 0) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      if (rv(sel)) begin
        seen  = 1;
        lat   = k;
        rdata = (sel == 0) ? if0.resp_rdata : if2.resp_rdata;
        err   = (sel == 0) ? if0.resp_err : if2.resp_err;
      end else begin
        @(negedge CLK);
        k++;
      end
    end
    if (!seen) $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
    @(negedge CLK);
    @(posedge CLK);
    check_eq("resp_one_cycle", 32'(rv(sel)), 32'h0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;

  initial begin
    n_cmp = 0; n_bad = 0;
    Reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    check_eq("rst_ready",  32'(if2.req_ready),  32'h0);
    check_eq("rst_busy",   32'(if2.busy),       32'h0);
    check_eq("rst_rvalid", 32'(if2.resp_valid), 32'h0);
    check_eq("rst_rdata",  if2.resp_rdata,      32'h0);
    check_eq("rst_err",    32'(if2.resp_err),   32'h0);
    Reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(if2.req_ready), 32'h1);

    // Store then load, two wait states.
    do_req(2, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check_eq("st10_rdata", rd, 32'h0);
    check_eq("st10_err", 32'(er), 32'h0);
    check_eq("st10_lat", 32'(lat), 32'd2);
    do_req(2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check_eq("ld10_rdata", rd, 32'hDEADBEEF);
    check_eq("ld10_lat", 32'(lat), 32'd2);

    // Zero wait states with req_valid held high across the response.
    drive(0, 1'b1, 1'b1, 32'h0, 32'h12345678);
    @(negedge CLK);
    @(posedge CLK);
    check_eq("ws0_st_rvalid", 32'(if0.resp_valid), 32'h1);
    check_eq("ws0_st_rdata", if0.resp_rdata, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    @(posedge CLK);
    check_eq("ws0_gap_rvalid", 32'(if0.resp_valid), 32'h0);
    check_eq("ws0_gap_ready", 32'(if0.req_ready), 32'h1);
    @(negedge CLK);
    @(posedge CLK);
    check_eq("ws0_ld_rvalid", 32'(if0.resp_valid), 32'h1);
    check_eq("ws0_ld_rdata", if0.resp_rdata, 32'h12345678);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    @(posedge CLK);
    check_eq("ws0_end_rvalid", 32'(if0.resp_valid), 32'h0);

    // Misaligned and out-of-range accesses.
    do_req(2, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check_eq("mis_err", 32'(er), 32'h1);
    check_eq("mis_rdata", rd, 32'h0);
    check_eq("mis_lat", 32'(lat), 32'd2);
    do_req(2, 1'b0, 32'h400, 32'h0, rd, er, lat);
    check_eq("oor_err", 32'(er), 32'h1);
    check_eq("oor_rdata", rd, 32'h0);
    do_req(2, 1'b1, 32'h0, 32'hCAFEF00D, rd, er, lat);
    do_req(2, 1'b1, 32'h400, 32'hFFFFFFFF, rd, er, lat);
    check_eq("oor_st_err", 32'(er), 32'h1);
    do_req(2, 1'b0, 32'h0, 32'h0, rd, er, lat);
    check_eq("no_wrap_rdata", rd, 32'hCAFEF00D);

    // Last legal word.
    do_req(2, 1'b1, 32'h3FC, 32'hA5A5A5A5, rd, er, lat);
    check_eq("last_st_err", 32'(er), 32'h0);
    do_req(2, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
    check_eq("last_ld_rdata", rd, 32'hA5A5A5A5);
    check_eq("last_ld_err", 32'(er), 32'h0);

    // Reset during WAIT discards the pending store.
    do_req(2, 1'b1, 32'h20, 32'h00000011, rd, er, lat);
    drive(2, 1'b1, 1'b1, 32'h20, 32'h00000055);
    @(negedge CLK);
    @(posedge CLK);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    Reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(if2.busy), 32'h0);
    check_eq("mid_rst_ready", 32'(if2.req_ready), 32'h0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    Reset = 1'b0;
    #1;
    check_eq("after_rst_ready", 32'(if2.req_ready), 32'h1);
    check_eq("after_rst_busy", 32'(if2.busy), 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      if (if2.resp_valid) pulses++;
    end
    check_eq("after_rst_no_resp", 32'(pulses), 32'h0);
    do_req(2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check_eq("after_rst_ld20", rd, 32'h00000011);

    // Toggling req_valid during WAIT/RESP must not be accepted.
    drive(2, 1'b1, 1'b1, 32'h30, 32'h00000077);
    @(negedge CLK);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      if (i == 0 || i == 2) drive(2, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
      else drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      if (if2.resp_valid) pulses++;
    end
    check_eq("toggle_pulses", 32'(pulses), 32'h1);
    check_eq("toggle_busy", 32'(if2.busy), 32'h0);
    do_req(2, 1'b0, 32'h30, 32'h0, rd, er, lat);
    check_eq("toggle_ld30", rd, 32'h00000077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
